// File: rtl/adder_27_feeder.sv
// ---------------------------------------------------------------------------
// adder_27_feeder
//
// Producer side of the adder_27 interface. Pixel/weight pairs arrive on a
// valid/ready stream. Each pair is multiplied in signed fixed point with
// FRAC_BITS fractional bits, rounded half-up, saturated to BITSIZE bits and
// written into the next product lane. After NUM_INPUTS pairs the lanes are
// presented to adder_27 with start_adder held high until data_valid returns
// the sum. The sum is then offered on a valid/ready output port.
//
// Optional feature: define FEEDER_SAT_CNT_EN to add the sat_count port, a
// 16-bit sticky counter of accepted pairs whose product saturated.
//
// Ports
//   clk            clock, all logic on the rising edge
//   rst            synchronous reset, active-high
//   in_valid       pixel/weight pair valid
//   in_ready       feeder accepts a pair this cycle
//   in_pixel       signed pixel
//   in_weight      signed weight
//   input_numbers  packed products, lane k = [k*BITSIZE +: BITSIZE]
//   start_adder    request to adder_27
//   sum_output     signed sum from adder_27
//   data_valid     sum_output valid
//   out_valid      out_data valid
//   out_ready      downstream accepts out_data
//   out_data       captured signed sum
//   sat_count      saturated-product count (FEEDER_SAT_CNT_EN only)
//   busy           high unless idle in S_FILL with an empty window
// ---------------------------------------------------------------------------
module adder_27_feeder #(
  parameter int BITSIZE    = 14,
  parameter int NUM_INPUTS = 27,
  parameter int FRAC_BITS  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BITSIZE-1:0]            in_pixel,
  input  logic [BITSIZE-1:0]            in_weight,
  output logic [NUM_INPUTS*BITSIZE-1:0] input_numbers,
  output logic                          start_adder,
  input  logic [BITSIZE-1:0]            sum_output,
  input  logic                          data_valid,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BITSIZE-1:0]            out_data,
`ifdef FEEDER_SAT_CNT_EN
  output logic [15:0]                   sat_count,
`endif
  output logic                          busy
);

  localparam int CNT_W = $clog2(NUM_INPUTS + 1);
  // One guard bit above the full product so the rounding add cannot wrap.
  localparam int PW    = 2 * BITSIZE + 1;

  localparam logic signed [PW-1:0] ROUND   = PW'(1) << (FRAC_BITS - 1);
  localparam logic signed [PW-1:0] SAT_MAX = {{(PW-BITSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic [CNT_W-1:0]     LAST    = CNT_W'(NUM_INPUTS - 1);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [CNT_W-1:0]   count_reg;
  logic               start_adder_reg;
  logic               out_valid_reg;
  logic [BITSIZE-1:0] out_data_reg;
  logic [BITSIZE-1:0] lane_reg [NUM_INPUTS];

  logic               accept;
  logic signed [PW-1:0] prod_full;
  logic signed [PW-1:0] prod_shift;
  logic               sat_hi;
  logic               sat_lo;
  logic [BITSIZE-1:0] prod_sat;

  // ---------------- product: multiply, round half-up, saturate ------------
  assign prod_full  = $signed(in_pixel) * $signed(in_weight) + ROUND;
  assign prod_shift = prod_full >>> FRAC_BITS;
  assign sat_hi     = (prod_shift > SAT_MAX);
  assign sat_lo     = (prod_shift < SAT_MIN);

  always_comb begin
    prod_sat = prod_shift[BITSIZE-1:0];
    if (sat_hi) begin
      prod_sat = SAT_MAX[BITSIZE-1:0];
    end else if (sat_lo) begin
      prod_sat = SAT_MIN[BITSIZE-1:0];
    end
  end

  // ---------------- FSM ---------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_FILL;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    case (state_reg)
      S_FILL: begin
        in_ready = 1'b1;
        if (in_valid && (count_reg == LAST)) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (data_valid) begin
          state_next = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_next = S_FILL;
        end
      end
      default: state_next = S_FILL;
    endcase
  end

  assign accept = in_valid & in_ready;

  // ---------------- control / output registers ----------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg       <= '0;
      start_adder_reg <= 1'b0;
      out_valid_reg   <= 1'b0;
      out_data_reg    <= '0;
    end else begin
      if (accept) begin
        count_reg <= count_reg + 1'b1;
        if (count_reg == LAST) begin
          start_adder_reg <= 1'b1;
        end
      end
      if ((state_reg == S_WAIT) && data_valid) begin
        out_data_reg    <= sum_output;
        start_adder_reg <= 1'b0;
        out_valid_reg   <= 1'b1;
      end
      if ((state_reg == S_OUT) && out_ready) begin
        out_valid_reg <= 1'b0;
        count_reg     <= '0;
      end
    end
  end

  // ---------------- product lanes -----------------------------------------
  // Lanes are only written by accepted pairs; after a window completes they
  // keep their old contents until the next window overwrites them.
  generate
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_lane
      always_ff @(posedge clk) begin
        if (rst) begin
          lane_reg[gi] <= '0;
        end else if (accept && (count_reg == CNT_W'(gi))) begin
          lane_reg[gi] <= prod_sat;
        end
      end
      assign input_numbers[gi*BITSIZE +: BITSIZE] = lane_reg[gi];
    end
  endgenerate

`ifdef FEEDER_SAT_CNT_EN
  logic [15:0] sat_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_count_reg <= '0;
    end else if (accept && (sat_hi || sat_lo) && (sat_count_reg != 16'hFFFF)) begin
      sat_count_reg <= sat_count_reg + 16'd1;
    end
  end

  assign sat_count = sat_count_reg;
`endif

  assign start_adder = start_adder_reg;
  assign out_valid   = out_valid_reg;
  assign out_data    = out_data_reg;
  assign busy        = !((state_reg == S_FILL) && (count_reg == '0));

endmodule

// File: tb/tb_adder_27_feeder.sv
// ---------------------------------------------------------------------------
// tb_adder_27_feeder
//
// Directed bench for adder_27_feeder. The bench plays the role of the
// window/weight fetch logic, of a stub adder_27 and of the downstream
// consumer. Expected lane values and sums are hand-derived constants or
// simple closed forms of the stimulus.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_adder_27_feeder;

  localparam int BITSIZE    = 14;
  localparam int NUM_INPUTS = 27;
  localparam int FRAC_BITS  = 8;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          in_valid;
  logic                          in_ready;
  logic [BITSIZE-1:0]            in_pixel;
  logic [BITSIZE-1:0]            in_weight;
  logic [NUM_INPUTS*BITSIZE-1:0] input_numbers;
  logic                          start_adder;
  logic [BITSIZE-1:0]            sum_output;
  logic                          data_valid;
  logic                          out_valid;
  logic                          out_ready;
  logic [BITSIZE-1:0]            out_data;
  logic                          busy;
`ifdef FEEDER_SAT_CNT_EN
  logic [15:0]                   sat_count;
`endif

  int check_cnt = 0;
  int error_cnt = 0;
  int hs_cnt    = 0;

  adder_27_feeder #(
    .BITSIZE   (BITSIZE),
    .NUM_INPUTS(NUM_INPUTS),
    .FRAC_BITS (FRAC_BITS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pixel     (in_pixel),
    .in_weight    (in_weight),
    .input_numbers(input_numbers),
    .start_adder  (start_adder),
    .sum_output   (sum_output),
    .data_valid   (data_valid),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
`ifdef FEEDER_SAT_CNT_EN
    .sat_count    (sat_count),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Input handshakes, sampled at the edge where they take effect.
  always @(posedge clk) begin
    if (in_valid && in_ready) begin
      hs_cnt <= hs_cnt + 1;
    end
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    check_cnt++;
    if (obs !== exp) begin
      error_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  function automatic int lane(input int k);
    logic signed [BITSIZE-1:0] v;
    v = input_numbers[k*BITSIZE +: BITSIZE];
    return int'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one pair and hold it until accepted; optional idle cycle after.
  task automatic send_pair(input int p, input int w, input bit gap);
    int n;
    in_pixel  = BITSIZE'(p);
    in_weight = BITSIZE'(w);
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check_val("in_ready_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
    if (gap) tick();
  endtask

  // Stub adder: keep data_valid low for 'delay' cycles, then return 'sum'.
  task automatic stub_adder(input string tag, input int delay, input int sum);
    bit all_high;
    all_high = 1'b1;
    for (int i = 0; i < delay; i++) begin
      if (!start_adder) all_high = 1'b0;
      tick();
    end
    check_val({tag, "_start_held"}, int'(all_high && start_adder), 1);
    data_valid = 1'b1;
    sum_output = BITSIZE'(sum);
    tick();
    data_valid = 1'b0;
    sum_output = '0;
    check_val({tag, "_out_valid"}, int'(out_valid), 1);
    check_val({tag, "_out_data"}, int'($signed(out_data)), sum);
    check_val({tag, "_start_low"}, int'(start_adder), 0);
  endtask

  // Downstream consumer: stall 'stall' cycles, then accept.
  task automatic drain(input string tag, input int stall, input int sum);
    bit stable;
    stable = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      tick();
      if (!out_valid || in_ready || ($signed(out_data) != BITSIZE'(sum))) stable = 1'b0;
    end
    check_val({tag, "_stall_stable"}, int'(stable), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val({tag, "_out_valid_drop"}, int'(out_valid), 0);
    check_val({tag, "_in_ready_back"}, int'(in_ready), 1);
    check_val({tag, "_busy_idle"}, int'(busy), 0);
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_pixel   = '0;
    in_weight  = '0;
    sum_output = '0;
    data_valid = 1'b0;
    out_ready  = 1'b0;
    repeat (3) tick();

    // ---------------- reset state ----------------
    check_val("rst_in_ready", int'(in_ready), 1);
    check_val("rst_start", int'(start_adder), 0);
    check_val("rst_out_valid", int'(out_valid), 0);
    check_val("rst_out_data", int'(out_data), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_lanes_zero", int'(input_numbers == '0), 1);
`ifdef FEEDER_SAT_CNT_EN
    check_val("rst_sat_count", int'(sat_count), 0);
`endif
    rst = 1'b0;
    tick();

    // ---------------- 1: pixel 1.0 times -(k+1), back to back --------------
    for (int k = 0; k < NUM_INPUTS - 1; k++) send_pair(256, -(k + 1), 1'b0);
    check_val("t1_start_before_last", int'(start_adder), 0);
    check_val("t1_busy_mid", int'(busy), 1);
    send_pair(256, -NUM_INPUTS, 1'b0);
    check_val("t1_start_after_last", int'(start_adder), 1);
    check_val("t1_in_ready_wait", int'(in_ready), 0);
    check_val("t1_handshakes", hs_cnt, NUM_INPUTS);
    for (int k = 0; k < NUM_INPUTS; k++) check_val($sformatf("t1_lane%0d", k), lane(k), -(k + 1));
    stub_adder("t1", 0, -378);
    drain("t1", 0, -378);

    // ---------------- 2/3: saturation and rounding, slow adder -------------
    send_pair(8191, 8191, 1'b0);
    send_pair(-8192, 8191, 1'b0);
    send_pair(1, 128, 1'b0);
    send_pair(-1, 128, 1'b0);
    send_pair(-1, -384, 1'b0);
    for (int k = 5; k < NUM_INPUTS; k++) send_pair(0, 0, 1'b0);
    check_val("t2_sat_pos", lane(0), 8191);
    check_val("t2_sat_neg", lane(1), -8192);
    check_val("t3_round_pos", lane(2), 1);
    check_val("t3_round_neg_half", lane(3), 0);
    check_val("t3_round_neg_neg", lane(4), 2);
    check_val("t3_lane26", lane(26), 0);
`ifdef FEEDER_SAT_CNT_EN
    check_val("t2_sat_count", int'(sat_count), 2);
`endif
    stub_adder("t5_delay20", 20, 2);
    drain("t2", 0, 2);

    // ---------------- 5: data_valid while filling is ignored ---------------
    data_valid = 1'b1;
    sum_output = BITSIZE'(123);
    tick();
    data_valid = 1'b0;
    sum_output = '0;
    check_val("t5_dv_ign_out_valid", int'(out_valid), 0);
    check_val("t5_dv_ign_in_ready", int'(in_ready), 1);
    check_val("t5_dv_ign_out_data", int'($signed(out_data)), 2);

    // ---------------- 4: toggling in_valid, out_ready stall ---------------
    hs_cnt = 0;
    for (int k = 0; k < NUM_INPUTS; k++) send_pair(512, k, 1'b1);
    check_val("t4_handshakes", hs_cnt, NUM_INPUTS);
    // Offers while not ready must not be stored.
    in_pixel  = BITSIZE'(256);
    in_weight = BITSIZE'(100);
    in_valid  = 1'b1;
    repeat (3) tick();
    in_valid  = 1'b0;
    check_val("t4_no_extra_hs", hs_cnt, NUM_INPUTS);
    check_val("t4_lane0", lane(0), 0);
    check_val("t4_lane13", lane(13), 26);
    check_val("t4_lane26", lane(26), 52);
    stub_adder("t4", 3, 702);
    drain("t4", 10, 702);

    // ---------------- 6: reset mid-window ----------------------------------
    for (int k = 0; k < 13; k++) send_pair(1000, 1000, 1'b0);
    check_val("t6_busy_partial", int'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("t6_in_ready", int'(in_ready), 1);
    check_val("t6_busy", int'(busy), 0);
    check_val("t6_out_valid", int'(out_valid), 0);
    check_val("t6_out_data", int'(out_data), 0);
    check_val("t6_start", int'(start_adder), 0);
    check_val("t6_lanes_zero", int'(input_numbers == '0), 1);
`ifdef FEEDER_SAT_CNT_EN
    check_val("t6_sat_count", int'(sat_count), 0);
`endif
    hs_cnt = 0;
    for (int k = 0; k < NUM_INPUTS; k++) send_pair(256, k + 1, 1'b0);
    check_val("t6_handshakes", hs_cnt, NUM_INPUTS);
    check_val("t6_lane0", lane(0), 1);
    check_val("t6_lane26", lane(26), 27);
    check_val("t6_start", int'(start_adder), 1);
    stub_adder("t6", 2, 378);
    drain("t6", 1, 378);

    $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
